if_fetch: RTL

Instruction-fetch front end of the CPU pipeline. It owns the fetch PC and issues single-outstanding requests to instruction memory. Returned words go into a 2-entry prefetch buffer that feeds the IF/ID boundary. It sits downstream of the next-PC selector: it presents the PC of the instruction in ID, and consumes the selector's computed next PC and flush pulse to redirect fetch and discard wrong-path instructions.

---
 rtl/if_fetch_pkg.sv | 20 ++
 rtl/if_fetch_buf.sv | 80 ++++++++
 rtl/if_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: default bus widths,
// FSM state encodings and prefetch buffer depth.
package if_fetch_pkg;

    // Default instruction-memory word address width (PC width).
    localparam int IF_ADDR_W = 8;

    // Default instruction width.
    localparam int IF_DATA_W = 32;

    // Prefetch buffer depth between the fetch unit and ID.
    localparam int IF_BUF_DEPTH = 2;

    // Fetch FSM encodings, kept as plain constants for compatibility with
    // existing decode in the surrounding pipeline.
    localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
    localparam logic [1:0] ST_WAIT = 2'd1;  // request outstanding, response kept
    localparam logic [1:0] ST_DROP = 2'd2;  // request outstanding, response discarded

endpackage : if_fetch_pkg

// File: rtl/if_fetch_buf.sv
// Two-entry prefetch FIFO holding {pc, instr} pairs. Entry 0 is always the
// head, so the ID-facing outputs come straight from flops.
module fetch_buf
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic [DATA_W-1:0] push_instr,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_pc,
    output logic [DATA_W-1:0] head_instr
);

    logic [ADDR_W-1:0] pc0_q, pc0_d;
    logic [ADDR_W-1:0] pc1_q, pc1_d;
    logic [DATA_W-1:0] instr0_q, instr0_d;
    logic [DATA_W-1:0] instr1_q, instr1_d;
    logic [1:0]        count_q, count_d;
    logic [1:0]        after_pop;

    // Next-state of the FIFO: pop shifts entry 1 down, push lands in the
    // first free slot left after the pop; clear only empties the count.
    always_comb begin
        pc0_d     = pc0_q;
        pc1_d     = pc1_q;
        instr0_d  = instr0_q;
        instr1_d  = instr1_q;
        count_d   = count_q;
        after_pop = count_q - {1'b0, pop};
        if (clear) begin
            count_d = '0;
        end else begin
            if (pop) begin
                pc0_d    = pc1_q;
                instr0_d = instr1_q;
            end
            if (push) begin
                if (after_pop != 2'd0) begin
                    pc1_d    = push_pc;
                    instr1_d = push_instr;
                end else begin
                    pc0_d    = push_pc;
                    instr0_d = push_instr;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // FIFO storage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc0_q    <= '0;
            pc1_q    <= '0;
            instr0_q <= '0;
            instr1_q <= '0;
            count_q  <= '0;
        end else begin
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_pc    = pc0_q;
    assign head_instr = instr0_q;

endmodule : fetch_buf

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding
// requests to instruction memory and feeds ID through a 2-entry prefetch
// buffer. Redirects from the next-PC selector flush the buffer and drop any
// in-flight wrong-path response.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = IF_ADDR_W,
    parameter int DATA_W = IF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] npc,
    input  logic              redirect,
    input  logic              stall_id,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              run_q, run_d;

    logic [1:0]        buf_count;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_clear;
    logic              ack_keep;
    logic [2:0]        occ_next;
    logic              issue;

    // Buffer control and issue decision. Redirect overrides push/pop; issue
    // waits one cycle after reset release (run_q) so no request is presented
    // while reset is asserted.
    always_comb begin
        ack_keep  = (state_q == ST_WAIT) && imem_ack;
        buf_clear = redirect;
        buf_pop   = id_valid && !stall_id && !redirect;
        buf_push  = ack_keep && !redirect;
        occ_next  = {1'b0, buf_count} + {2'b00, buf_push} - {2'b00, buf_pop};
        issue     = run_q && !redirect && (occ_next < 3'd2) &&
                    ((state_q == ST_IDLE) || ack_keep);
    end

    // Next fetch PC, latched request PC and FSM state.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        run_d      = 1'b1;
        if (redirect) begin
            fetch_pc_d = npc;
            case (state_q)
                ST_WAIT: state_d = imem_ack ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = imem_ack ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else if (issue) begin
            state_d    = ST_WAIT;
            fetch_pc_d = fetch_pc_q + 1'b1;
            req_pc_d   = fetch_pc_q;
        end else if (((state_q == ST_WAIT) || (state_q == ST_DROP)) && imem_ack) begin
            state_d = ST_IDLE;
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            req_pc_q   <= '0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            run_q      <= run_d;
        end
    end

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    fetch_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .pop        (buf_pop),
        .clear      (buf_clear),
        .push_pc    (req_pc_q),
        .push_instr (imem_rdata),
        .count      (buf_count),
        .head_valid (id_valid),
        .head_pc    (id_pc),
        .head_instr (id_instr)
    );

endmodule : if_fetch
